seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter PAT_INIT, default 4'b1011, pattern after reset; first-received bit is the MSB.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port en, input, 1, qualifies x; bit sampled only when en=1.
REQ-008 SHALL have port x, input, 1, serial data bit.
REQ-009 SHALL have port pat_load, input, 1, one-cycle request to replace the active pattern.
REQ-010 SHALL have port pat_in, input, PAT_W, new pattern; sampled when pat_load=1.
REQ-011 SHALL have port cnt_clr, input, 1, clears the match counter.
REQ-012 SHALL have port y, output, 1, registered match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W, saturating count of matches.
REQ-014 SHALL have port armed, output, 1, high when the history holds at least PAT_W valid bits.

Function
REQ-015 SHALL keep a PAT_W-bit history shift register; each accepted bit enters the LSB, and the oldest bit sits at the MSB.
REQ-016 SHALL keep a fill counter (0..PAT_W) of valid history bits, incremented per accepted bit and saturating at PAT_W.
REQ-017 SHALL implement the FSM states FILL (fill<PAT_W) and ARMED (fill=PAT_W); armed=1 exactly in ARMED.
REQ-018 SHALL declare a match on the edge accepting a bit when the post-shift history equals the active pattern and the post-shift fill equals PAT_W.
REQ-019 SHALL drive y=1 for exactly the one cycle following the matching edge (latency 1 clock from the sampled bit); y=0 otherwise.
REQ-020 SHALL, with OVERLAP=1, keep history and fill after a match, so a sliding match may occur on the next accepted bit.
REQ-021 SHALL, with OVERLAP=0, set fill to 0 on a match (state FILL); the next match then requires PAT_W fresh bits.
REQ-022 SHALL hold all state when en=0, with y=0 in the following cycle.
REQ-023 SHALL, on pat_load=1, load pat_in as the active pattern, clear history and fill to 0, and discard any bit presented in that cycle; y=0 next cycle.
REQ-024 SHALL increment match_cnt by 1 per match and saturate at 2^CNT_W-1 with no wrap.
REQ-025 SHALL, when cnt_clr=1 without a match, set match_cnt to 0; when cnt_clr and a match coincide, set match_cnt to 1.
REQ-026 SHALL, when pat_load and cnt_clr coincide, perform both; pat_load never affects match_cnt otherwise.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set the active pattern to PAT_INIT, history to 0, fill to 0, state to FILL, y=0, match_cnt=0, and armed=0.
REQ-028 SHALL give rst priority over pat_load, cnt_clr and en; reset mid-stream discards partial history.

Structure
REQ-029 SHALL take its FSM state encoding constants (FILL, ARMED) from the shared package fsm_pkg.
REQ-030 SHALL instantiate exactly one sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, clr, count), for match_cnt.

Verification
REQ-031 SHALL cover: defaults, en=1, x stream 1,0,1,1 -> y=1 in the cycle after the 4th bit, match_cnt=1.
REQ-032 SHALL cover: OVERLAP=1, stream 1,0,1,1,0,1,1 -> two y pulses (after bits 4 and 7), match_cnt=2; OVERLAP=0 with pattern 1010 and stream 1,0,1,0,1,0 -> one pulse.
REQ-033 SHALL cover: en toggled low between bits of 1,0,1,1 -> still exactly one match, with y only after the last accepted bit.
REQ-034 SHALL cover: pat_load with pat_in=4'b0110 after bits 1,0 -> armed=0; then 0,1,1,0 -> match; old-pattern bits never match.
REQ-035 SHALL cover: CNT_W=2 with 5 matches -> match_cnt holds 3; cnt_clr coincident with a match -> match_cnt=1.
REQ-036 SHALL cover: rst asserted after bits 1,0,1, then bit 1 -> no y; match_cnt=0, armed=0.

Source files
------------

// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared FSM state encoding and sizing helper for the sequence detector
package fsm_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } fsm_state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter; clear wins over hold but still counts a coincident increment
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - serial pattern detector with loadable pattern, overlap control and match counter
module seq_detect_param
  import fsm_pkg::*;
#(
  parameter int                PAT_W    = 4,
  parameter logic [PAT_W-1:0]  PAT_INIT = PAT_W'(4'b1011),
  parameter int                OVERLAP  = 1,
  parameter int                CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int              FW       = fill_width(PAT_W);
  localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0]   FILL_ONE = FW'(1);

  fsm_state_t       state, state_d;
  logic [PAT_W-1:0] pat, pat_d;
  logic [PAT_W-1:0] hist, hist_d, hist_shift;
  logic [FW-1:0]    fill, fill_d, fill_inc;
  logic             match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      pat   <= PAT_INIT;
      hist  <= '0;
      fill  <= '0;
      y     <= 1'b0;
    end else begin
      state <= state_d;
      pat   <= pat_d;
      hist  <= hist_d;
      fill  <= fill_d;
      y     <= match;
    end
  end

  // A pattern load takes precedence over the bit presented in the same cycle.
  always_comb begin
    hist_shift = {hist[PAT_W-2:0], x};
    fill_inc   = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_ONE;
    pat_d      = pat;
    hist_d     = hist;
    fill_d     = fill;
    match      = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if ((hist_shift == pat) && (fill_inc == FILL_MAX)) begin
        match = 1'b1;
        if (OVERLAP == 0) begin
          fill_d = '0;
        end
      end
    end
    state_d = (fill_d == FILL_MAX) ? ARMED : FILL;
  end

  assign armed = (state == ARMED);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param across three parameter sets
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, x0, pl0, clr0, y0, armed0;
  logic [3:0] pin0;
  logic [7:0] cnt0;
  logic       rst1, en1, x1, pl1, clr1, y1, armed1;
  logic [3:0] pin1;
  logic [7:0] cnt1;
  logic       rst2, en2, x2, pl2, clr2, y2, armed2;
  logic [3:0] pin2;
  logic [1:0] cnt2;

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .x(x0), .pat_load(pl0), .pat_in(pin0),
    .cnt_clr(clr0), .y(y0), .match_cnt(cnt0), .armed(armed0));

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1010), .OVERLAP(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .x(x1), .pat_load(pl1), .pat_in(pin1),
    .cnt_clr(clr1), .y(y1), .match_cnt(cnt1), .armed(armed1));

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .x(x2), .pat_load(pl2), .pat_in(pin2),
    .cnt_clr(clr2), .y(y2), .match_cnt(cnt2), .armed(armed2));

  int   n_run  = 0;
  int   n_fail = 0;
  logic exp_q[$];
  logic got, want;

  function automatic logic y_of(input int d);
    case (d)
      0:       return y0;
      1:       return y1;
      default: return y2;
    endcase
  endfunction

  // Drive one cycle on DUT d (others idle), queue the expected y for that edge.
  task automatic cyc(input int d, input logic r, input logic e, input logic xb,
                     input logic pl, input logic [3:0] pin, input logic clr, input logic ey);
    {rst0, en0, x0, pl0, clr0} = '0; pin0 = '0;
    {rst1, en1, x1, pl1, clr1} = '0; pin1 = '0;
    {rst2, en2, x2, pl2, clr2} = '0; pin2 = '0;
    case (d)
      0:       begin rst0 = r; en0 = e; x0 = xb; pl0 = pl; pin0 = pin; clr0 = clr; end
      1:       begin rst1 = r; en1 = e; x1 = xb; pl1 = pl; pin1 = pin; clr1 = clr; end
      default: begin rst2 = r; en2 = e; x2 = xb; pl2 = pl; pin2 = pin; clr2 = clr; end
    endcase
    exp_q.push_back(ey);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    cyc(d, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    exp_q.delete();
    n_run++; if (y0 !== 1'b0)     begin n_fail++; $display("FAIL reset_y: got %b want 0", y0); end
    n_run++; if (armed0 !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b want 0", armed0); end
    n_run++; if (cnt0 !== 8'd0)   begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", cnt0); end
    n_run++; if (cnt1 !== 8'd0 || armed1 !== 1'b0)
      begin n_fail++; $display("FAIL reset_dut1: cnt %0d armed %b want 0 0", cnt1, armed1); end
    n_run++; if (cnt2 !== 2'd0)   begin n_fail++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b1011;
    logic [3:0] ey   = 4'b0001;
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 1'b1, bits[3-i], 1'b0, 4'b0, 1'b0, ey[3-i]);
      got = y_of(0); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL basic_y[%0d]: got %b want %b", i, got, want); end
      if (i == 2) begin
        n_run++; if (armed0 !== 1'b0) begin n_fail++; $display("FAIL basic_armed3: got %b want 0", armed0); end
      end
    end
    n_run++; if (armed0 !== 1'b1) begin n_fail++; $display("FAIL basic_armed4: got %b want 1", armed0); end
    n_run++; if (cnt0 !== 8'd1)   begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", cnt0); end
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
    got = y_of(0); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL clr_y: got %b want %b", got, want); end
    n_run++; if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", cnt0); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] ey   = 7'b0001001;
    do_reset(0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1'b0, 1'b1, bits[6-i], 1'b0, 4'b0, 1'b0, ey[6-i]);
      got = y_of(0); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL overlap_y[%0d]: got %b want %b", i, got, want); end
    end
    n_run++; if (cnt0 !== 8'd2) begin n_fail++; $display("FAIL overlap_cnt: got %0d want 2", cnt0); end
  endtask

  task automatic test_en_gaps();
    logic [8:0] en_s = 9'b101001010;
    logic [8:0] x_s  = 9'b100111110;
    logic [8:0] ey   = 9'b000000010;
    do_reset(0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1'b0, en_s[8-i], x_s[8-i], 1'b0, 4'b0, 1'b0, ey[8-i]);
      got = y_of(0); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL en_gap_y[%0d]: got %b want %b", i, got, want); end
    end
    n_run++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL en_gap_cnt: got %0d want 1", cnt0); end
  endtask

  task automatic test_nonoverlap();
    logic [5:0] bits = 6'b101010;
    logic [5:0] ey   = 6'b000100;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1'b0, 1'b1, bits[5-i], 1'b0, 4'b0, 1'b0, ey[5-i]);
      got = y_of(1); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL nonovl_y[%0d]: got %b want %b", i, got, want); end
      if (i == 3) begin
        n_run++; if (armed1 !== 1'b0) begin n_fail++; $display("FAIL nonovl_armed: got %b want 0", armed1); end
      end
    end
    n_run++; if (cnt1 !== 8'd1) begin n_fail++; $display("FAIL nonovl_cnt: got %0d want 1", cnt1); end
  endtask

  task automatic test_saturate();
    logic [15:0] bits = 16'b1011011011011011;
    logic [15:0] ey   = 16'b0001001001001001;
    logic [3:0]  tb   = 4'b0110;
    logic [3:0]  tc   = 4'b0010;
    logic [3:0]  te   = 4'b0010;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      cyc(2, 1'b0, 1'b1, bits[15-i], 1'b0, 4'b0, 1'b0, ey[15-i]);
      got = y_of(2); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL sat_y[%0d]: got %b want %b", i, got, want); end
    end
    n_run++; if (cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", cnt2); end
    // Bits 0,1,1 with clear on the final (matching) bit, then a lone clear.
    for (int i = 0; i < 4; i++) begin
      cyc(2, 1'b0, (i != 3), tb[3-i], 1'b0, 4'b0, tc[3-i] | (i == 3), te[3-i]);
      got = y_of(2); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL satclr_y[%0d]: got %b want %b", i, got, want); end
      if (i == 2) begin
        n_run++; if (cnt2 !== 2'd1) begin n_fail++; $display("FAIL clr_match_cnt: got %0d want 1", cnt2); end
      end
    end
    n_run++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL sat_clr_only: got %0d want 0", cnt2); end
  endtask

  task automatic test_pat_load();
    logic [1:0] pre   = 2'b10;
    logic [5:0] bits  = 6'b011011;
    logic [5:0] ey    = 6'b000100;
    do_reset(0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1'b0, 1'b1, pre[1-i], 1'b0, 4'b0, 1'b0, 1'b0);
      got = y_of(0); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL load_pre_y[%0d]: got %b want %b", i, got, want); end
    end
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    got = y_of(0); want = exp_q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL load_y: got %b want %b", got, want); end
    n_run++; if (armed0 !== 1'b0) begin n_fail++; $display("FAIL load_armed: got %b want 0", armed0); end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b0, 1'b1, bits[5-i], 1'b0, 4'b0, 1'b0, ey[5-i]);
      got = y_of(0); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL load_y[%0d]: got %b want %b", i, got, want); end
    end
    n_run++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL load_cnt: got %0d want 1", cnt0); end
  endtask

  task automatic test_rst_mid();
    logic [5:0] bits = 6'b101101;
    logic [5:0] ey   = 6'b000100;
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b0, 1'b1, bits[5-i], 1'b0, 4'b0, 1'b0, ey[5-i]);
      got = y_of(0); want = exp_q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL rstmid_y[%0d]: got %b want %b", i, got, want); end
    end
    n_run++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL rstmid_precnt: got %0d want 1", cnt0); end
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? 1'b0 : y_of(0);
      want = exp_q.pop_front();
      if (i == 1) begin
        n_run++;
        if (got !== want) begin n_fail++; $display("FAIL rstmid_y_after: got %b want %b", got, want); end
      end
    end
    n_run++; if (cnt0 !== 8'd0)   begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", cnt0); end
    n_run++; if (armed0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_armed: got %b want 0", armed0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_en_gaps();
    test_nonoverlap();
    test_saturate();
    test_pat_load();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
